// File: rtl/pitch_pkg.sv
// Shared definitions for the note detector: FSM states, semitone table and
// lock window. NOTE_DETECT_AVG4_EN switches the measurement to a sum of four
// periods and widens the divider to match.
package pitch_pkg;

`ifdef NOTE_DETECT_AVG4_EN
    localparam int AVG_N     = 4;
    localparam int DIV_W     = 36;
    localparam int SUM_EXTRA = 2;
`else
    localparam int AVG_N     = 1;
    localparam int DIV_W     = 34;
    localparam int SUM_EXTRA = 0;
`endif

    // Midpoints B2/C3 and B6/C7; anything outside is reported unlocked.
    localparam logic [19:0] F_MIN_X100 = 20'd12714;
    localparam logic [19:0] F_MAX_X100 = 20'd203428;

    typedef enum logic [2:0] {
        ARM,
        COUNT,
        DIVIDE,
        SEARCH,
        DONE
    } state_t;

    // Octave-3 semitone frequencies x100, C..B.
    function automatic logic [15:0] base_x100(input logic [3:0] note);
        case (note)
            4'd0:    base_x100 = 16'd13081;
            4'd1:    base_x100 = 16'd13859;
            4'd2:    base_x100 = 16'd14683;
            4'd3:    base_x100 = 16'd15556;
            4'd4:    base_x100 = 16'd16481;
            4'd5:    base_x100 = 16'd17461;
            4'd6:    base_x100 = 16'd18500;
            4'd7:    base_x100 = 16'd19600;
            4'd8:    base_x100 = 16'd20765;
            4'd9:    base_x100 = 16'd22000;
            4'd10:   base_x100 = 16'd23308;
            4'd11:   base_x100 = 16'd24694;
            default: base_x100 = 16'd0;
        endcase
    endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per clock, DVD_W steps.
// done is high during the final step; quotient is valid from the next cycle
// and holds until the following start.
module seq_divider #(
    parameter int DVD_W = 34,
    parameter int DVS_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DVS_W-1:0] divisor,
    output logic [DVD_W-1:0] quotient,
    output logic             done
);

    localparam int CW = $clog2(DVD_W + 1);

    logic [DVD_W-1:0] quo;
    logic [DVS_W-1:0] rem;
    logic [DVS_W-1:0] dvs;
    logic [CW-1:0]    step;
    logic             run;
    logic [DVS_W:0]   rem_sh;
    logic [DVS_W:0]   rem_sub;
    logic             ge;

    // Trial subtraction of the divisor from the shifted partial remainder.
    always_comb begin
        rem_sh  = {rem, quo[DVD_W-1]};
        rem_sub = rem_sh - {1'b0, dvs};
        ge      = (rem_sh >= {1'b0, dvs});
    end

    // Load on start, then shift one quotient bit in per cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            quo  <= '0;
            rem  <= '0;
            dvs  <= '0;
            step <= '0;
            run  <= 1'b0;
        end else if (start) begin
            quo  <= dividend;
            rem  <= '0;
            dvs  <= divisor;
            step <= CW'(DVD_W);
            run  <= 1'b1;
        end else if (run) begin
            quo  <= {quo[DVD_W-2:0], ge};
            rem  <= ge ? rem_sub[DVS_W-1:0] : rem_sh[DVS_W-1:0];
            step <= step - 1'b1;
            run  <= (step != CW'(1));
        end
    end

    assign done     = run && (step == CW'(1));
    assign quotient = quo;

endmodule

// File: rtl/note_detect.sv
// Square-wave pitch detector: period -> frequency x100 -> nearest semitone
// in C3..B6. Build option NOTE_DETECT_AVG4_EN averages four periods.
//
// state  | meaning
// ARM    | wait for a rising edge to start a period
// COUNT  | count clocks until the closing edge or timeout
// DIVIDE | CLK_HZ*100*AVG_N / period on the sequential divider
// SEARCH | scan 48 semitone candidates for the closest one
// DONE   | result published (valid pulse), back to ARM
module note_detect
    import pitch_pkg::*;
#(
    parameter int CLK_HZ   = 50_000_000,
    parameter int PERIOD_W = 24
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sig_in,
    output logic [3:0]  note_out,
    output logic [1:0]  octave_out,
    output logic [19:0] freq_x100_out,
    output logic        valid,
    output logic        locked,
    output logic        busy
);

    localparam int SUM_W = PERIOD_W + SUM_EXTRA;
    localparam logic [DIV_W-1:0] DIVIDEND = DIV_W'(64'(CLK_HZ) * 64'(100 * AVG_N));

    state_t             state, state_nxt;
    logic               sync1, sync2, sync_prev, rise;
    logic [PERIOD_W-1:0] cnt;
    logic [SUM_W-1:0]   sum, period_len, sum_nxt;
    logic [1:0]         pcnt;
    logic               cnt_max, last_period, div_start, div_done;
    logic [DIV_W-1:0]   quot;
    logic [19:0]        freq, cand, diff, best_diff, sel_diff;
    logic [3:0]         s_note, best_note, sel_note;
    logic [1:0]         s_oct, best_oct, sel_oct;
    logic               take, search_last, in_range;

    // Two-flop synchroniser plus previous-value flop for rising-edge detect.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            sync_prev <= 1'b0;
        end else begin
            sync1     <= sig_in;
            sync2     <= sync1;
            sync_prev <= sync2;
        end
    end

    assign rise = sync2 && !sync_prev;

    // Period arithmetic, divider launch, saturation and candidate distance.
    always_comb begin
        cnt_max     = &cnt;
        period_len  = SUM_W'(cnt) + 1'b1;
        sum_nxt     = sum + period_len;
        last_period = (pcnt == 2'(AVG_N - 1));
        div_start   = (state == COUNT) && rise && !cnt_max && last_period;
        freq        = (|quot[DIV_W-1:20]) ? 20'hFFFFF : quot[19:0];
        cand        = 20'(base_x100(s_note)) << s_oct;
        diff        = (freq >= cand) ? (freq - cand) : (cand - freq);
        take        = ((s_note == 4'd0) && (s_oct == 2'd0)) || (diff < best_diff);
        sel_diff    = take ? diff   : best_diff;
        sel_note    = take ? s_note : best_note;
        sel_oct     = take ? s_oct  : best_oct;
        search_last = (s_note == 4'd11) && (s_oct == 2'd3);
        in_range    = (freq >= F_MIN_X100) && (freq <= F_MAX_X100);
    end

    seq_divider #(
        .DVD_W (DIV_W),
        .DVS_W (SUM_W)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .dividend (DIVIDEND),
        .divisor  (sum_nxt),
        .quotient (quot),
        .done     (div_done)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= ARM;
        else        state <= state_nxt;
    end

    // Next-state decode; timeout wins over a coincident edge.
    always_comb begin
        state_nxt = state;
        case (state)
            ARM:     if (rise) state_nxt = COUNT;
            COUNT: begin
                if (cnt_max)                  state_nxt = ARM;
                else if (rise && last_period) state_nxt = DIVIDE;
            end
            DIVIDE:  if (div_done) state_nxt = SEARCH;
            SEARCH:  if (search_last) state_nxt = DONE;
            DONE:    state_nxt = ARM;
            default: state_nxt = ARM;
        endcase
    end

    // Period counter and multi-period accumulator.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt  <= '0;
            sum  <= '0;
            pcnt <= '0;
        end else if (state == ARM) begin
            if (rise) begin
                cnt  <= '0;
                sum  <= '0;
                pcnt <= '0;
            end
        end else if (state == COUNT) begin
            if (rise && !cnt_max) begin
                cnt  <= '0;
                sum  <= sum_nxt;
                pcnt <= pcnt + 1'b1;
            end else begin
                cnt  <= cnt + 1'b1;
            end
        end
    end

    // Candidate walk and running best match.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_note    <= '0;
            s_oct     <= '0;
            best_diff <= '0;
            best_note <= '0;
            best_oct  <= '0;
        end else if (state == SEARCH) begin
            best_diff <= sel_diff;
            best_note <= sel_note;
            best_oct  <= sel_oct;
            if (s_note == 4'd11) begin
                s_note <= '0;
                s_oct  <= s_oct + 1'b1;
            end else begin
                s_note <= s_note + 1'b1;
            end
        end else begin
            s_note <= '0;
            s_oct  <= '0;
        end
    end

    // Published result; registers land in the DONE cycle alongside valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid         <= 1'b0;
            locked        <= 1'b0;
            freq_x100_out <= '0;
            note_out      <= '0;
            octave_out    <= '0;
        end else begin
            valid <= 1'b0;
            if ((state == COUNT) && cnt_max) begin
                valid         <= 1'b1;
                locked        <= 1'b0;
                freq_x100_out <= '0;
            end else if ((state == SEARCH) && search_last) begin
                valid         <= 1'b1;
                freq_x100_out <= freq;
                locked        <= in_range;
                if (in_range) begin
                    note_out   <= sel_note;
                    octave_out <= sel_oct;
                end
            end
        end
    end

    assign busy = (state == DIVIDE) || (state == SEARCH);

endmodule

// File: tb/tb_note_detect.sv
// Scoreboard bench for note_detect at CLK_HZ=1 MHz, PERIOD_W=16.
module tb_note_detect;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sig_in = 1'b0;
    logic [3:0]  note_out;
    logic [1:0]  octave_out;
    logic [19:0] freq_x100_out;
    logic        valid, locked, busy;

    note_detect #(
        .CLK_HZ   (1_000_000),
        .PERIOD_W (16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .sig_in        (sig_in),
        .note_out      (note_out),
        .octave_out    (octave_out),
        .freq_x100_out (freq_x100_out),
        .valid         (valid),
        .locked        (locked),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int freq;
        int note;
        int oct;
        int lock;
        int t0;
        int lat_lo;
        int lat_hi;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int f, input int nt, input int oc, input int lk,
                            input int lo, input int hi);
        exp_t e;
        e.freq   = f;
        e.note   = nt;
        e.oct    = oc;
        e.lock   = lk;
        e.t0     = cyc;
        e.lat_lo = lo;
        e.lat_hi = hi;
        sb.push_back(e);
    endtask

    task automatic wait_drain(input int bound);
        int i = 0;
        while (sb.size() != 0 && i < bound) begin
            tick(1);
            i++;
        end
        if (sb.size() != 0) begin
            chk("valid_never_seen", sb.size(), 0);
            sb.delete();
        end
    endtask

    // Two rising edges p cycles apart; sig_in rise to valid is 2 + 83 cycles.
    task automatic measure(input int p, input int f, input int nt, input int oc,
                           input int lk, input bit chk_busy);
        tick(3);
        sig_in = 1'b1;
        tick(p / 2);
        sig_in = 1'b0;
        tick(p - p / 2);
        sig_in = 1'b1;
        push_exp(f, nt, oc, lk, 85, 85);
        if (chk_busy) begin
            tick(10);
            chk("busy_in_divide", busy, 1);
            tick(30);
            sig_in = 1'b0;
            tick(44);
            chk("busy_last_search", busy, 1);
            tick(1);
            chk("busy_in_done", busy, 0);
            chk("valid_in_done", valid, 1);
        end else begin
            tick(40);
            sig_in = 1'b0;
        end
        wait_drain(300);
    endtask

    // Compare every valid pulse against the oldest expectation.
    always @(negedge clk) begin : mon
        exp_t e;
        int   lat;
        if (rst_n && valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_valid", 1, 0);
            end else begin
                e   = sb.pop_front();
                lat = cyc - e.t0;
                chk("freq_x100", freq_x100_out, e.freq);
                chk("note", note_out, e.note);
                chk("octave", octave_out, e.oct);
                chk("locked", locked, e.lock);
                if (e.lat_lo == e.lat_hi) chk("latency", lat, e.lat_lo);
                else chk("timeout_latency_window", (lat >= e.lat_lo) && (lat <= e.lat_hi), 1);
            end
        end
    end

    initial begin
        rst_n  = 1'b0;
        sig_in = 1'b0;
        tick(3);
        chk("rst_valid", valid, 0);
        chk("rst_locked", locked, 0);
        chk("rst_busy", busy, 0);
        chk("rst_freq", freq_x100_out, 0);
        chk("rst_note", note_out, 0);
        chk("rst_octave", octave_out, 0);
        rst_n = 1'b1;
        tick(2);

        measure(2273, 43994, 9, 1, 1, 1'b1);
        measure(506, 197628, 11, 3, 1, 1'b0);
        measure(4545, 22002, 9, 0, 1, 1'b0);
        measure(10000, 10000, 9, 0, 0, 1'b0);

        // Lone edge, input then idles low: timeout, note/octave held.
        tick(3);
        sig_in = 1'b1;
        push_exp(0, 9, 0, 0, 65530, 65545);
        tick(10);
        sig_in = 1'b0;
        wait_drain(70000);
        chk("timeout_busy", busy, 0);

        measure(7645, 13080, 0, 0, 1, 1'b0);

        // Reset pulse while dividing: no result, everything cleared.
        tick(3);
        sig_in = 1'b1;
        tick(300);
        sig_in = 1'b0;
        tick(300);
        sig_in = 1'b1;
        tick(20);
        chk("pre_reset_busy", busy, 1);
        rst_n  = 1'b0;
        sig_in = 1'b0;
        tick(1);
        chk("abort_valid", valid, 0);
        chk("abort_locked", locked, 0);
        chk("abort_busy", busy, 0);
        chk("abort_freq", freq_x100_out, 0);
        chk("abort_note", note_out, 0);
        chk("abort_octave", octave_out, 0);
        rst_n = 1'b1;
        tick(200);
        measure(506, 197628, 11, 3, 1, 1'b0);

        tick(5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
